// File: rtl/color_cvt_12to18.sv
// 12-to-18-bit colour reconstruction: integrates each channel's dithered LSB
// over a 7-phase window and rebuilds {upper 3 bits, count of LSB ones}.
module color_cvt_12to18 #(
   parameter bit HOLD_ON_ERR = 1'b0
) (
   input  logic       clk7x,
   input  logic       rst,
   input  logic       sync,
   input  logic [3:0] ri,
   input  logic [3:0] gi,
   input  logic [3:0] bi,
   output logic [5:0] ro,
   output logic [5:0] go,
   output logic [5:0] bo,
   output logic       vld,
   output logic       err
);

   logic [2:0]      phase_p0;
   logic [2:0]      ph_cur;
   logic [2:0][3:0] pix;
   logic [2:0][2:0] acc_p0;
   logic [2:0][2:0] hi_cap_p0;
   logic [2:0][2:0] sum;
   logic [2:0]      ch_mm;
   logic            mm_flag_p0;
   logic            win_mm;

   assign pix = {bi, gi, ri};

   // sync overrides the counter so the current sample becomes phase 0
   always_comb begin
      ph_cur = sync ? 3'd0 : phase_p0;
      for (int i = 0; i < 3; i++) begin
         sum[i]   = acc_p0[i] + {2'b00, pix[i][0]};
         ch_mm[i] = (pix[i][3:1] != hi_cap_p0[i]);
      end
      win_mm = mm_flag_p0 | (|ch_mm);
   end

   // ---- window accumulation and result stage ----
   always_ff @(posedge clk7x) begin
      if (rst) begin
         phase_p0   <= 3'd0;
         acc_p0     <= '0;
         hi_cap_p0  <= '0;
         mm_flag_p0 <= 1'b0;
         ro         <= '0;
         go         <= '0;
         bo         <= '0;
         vld        <= 1'b0;
         err        <= 1'b0;
      end else begin
         phase_p0 <= (ph_cur == 3'd6) ? 3'd0 : ph_cur + 3'd1;
         vld      <= 1'b0;
         err      <= 1'b0;
         if (ph_cur == 3'd0) begin
            for (int i = 0; i < 3; i++) begin
               acc_p0[i]    <= {2'b00, pix[i][0]};
               hi_cap_p0[i] <= pix[i][3:1];
            end
            mm_flag_p0 <= 1'b0;
         end else begin
            acc_p0 <= sum;
            if (|ch_mm)
               mm_flag_p0 <= 1'b1;
            if (ph_cur == 3'd6) begin
               vld <= 1'b1;
               err <= win_mm;
               // with HOLD_ON_ERR a corrupted window leaves the last good pixel in place
               if (!win_mm || !HOLD_ON_ERR) begin
                  ro <= {hi_cap_p0[0], sum[0]};
                  go <= {hi_cap_p0[1], sum[1]};
                  bo <= {hi_cap_p0[2], sum[2]};
               end
            end
         end
      end
   end

endmodule
